sram_bank: RTL

SRAM_BANK -- requirements
Module: sram_bank

---
 rtl/sram_bank_if.sv | 28 ++
 rtl/sram_bank.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sram_bank_if.sv
// Request/response bundle for sram_bank: write port, read port, read result and clear status.
interface sram_bank_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_WIDTH = 8
) ();
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [NUM_BYTES-1:0]  wr_be;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  init_busy;

    modport master (
        output wr_en, wr_ptr, wr_be, wr_data, rd_en, rd_ptr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_ptr, wr_be, wr_data, rd_en, rd_ptr,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/sram_bank.sv
// Byte-lane writable single-clock RAM with 1- or 2-cycle registered read and selectable collision mode.
// Define SRAM_BANK_INIT_EN to build the post-reset zero-clear sequencer (init_busy otherwise tied low).
module sram_bank #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RD_MODE    = 0
) (
    input  logic       clk,
    input  logic       rst,
    sram_bank_if.slave bus
);
    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] be_mask;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_fire;
    logic                  rd_fire;

`ifdef SRAM_BANK_INIT_EN
    typedef enum logic {INIT, READY} state_t;

    state_t              state;
    logic [ADDR_WIDTH:0] clr_cnt;

    // Extra counter bit keeps the count from aliasing address 0 on the final clear write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else if (state == INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt[ADDR_WIDTH-1:0] == '1) begin
                state <= READY;
                busy  <= 1'b0;
            end
        end
    end

    assign clr_we   = (state == INIT) && !rst;
    assign clr_addr = clr_cnt[ADDR_WIDTH-1:0];
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign wr_fire = bus.wr_en && !busy && !rst;
    assign rd_fire = bus.rd_en && !busy && !rst;

    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
        assign be_mask[g*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{bus.wr_be[g]}};
    end

    assign wr_merged = (mem[bus.wr_ptr] & ~be_mask) | (bus.wr_data & be_mask);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_fire) begin
            mem[bus.wr_ptr] <= wr_merged;
        end
    end

    // Write-first forwards the merged word so unselected lanes still return old contents.
    always_comb begin
        rd_word = mem[bus.rd_ptr];
        if (RD_MODE == 1 && wr_fire && bus.wr_ptr == bus.rd_ptr) begin
            rd_word = wr_merged;
        end
    end

    logic                  v1;
    logic [DATA_WIDTH-1:0] d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_fire;
            if (rd_fire) begin
                d1 <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  v2;
        logic [DATA_WIDTH-1:0] d2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) begin
                    d2 <= d1;
                end
            end
        end

        assign bus.rd_valid = v2;
        assign bus.rd_data  = d2;
    end else begin : g_lat1
        assign bus.rd_valid = v1;
        assign bus.rd_data  = d1;
    end

    assign bus.init_busy = busy;
endmodule
